// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: parses AA/BB/CC/DD frames into register-file
// and ALU transactions and returns read data / ALU results LSB-first to the transmitter.
module uart_rx_cmd_ctrl #(
  parameter int               WIDTH   = 8,
  parameter int               ADDR_W  = 4,
  parameter int               FUNC_W  = 4,
  parameter logic [WIDTH-1:0] OP_WR   = 8'hAA,
  parameter logic [WIDTH-1:0] OP_RD   = 8'hBB,
  parameter logic [WIDTH-1:0] OP_ALU  = 8'hCC,
  parameter logic [WIDTH-1:0] OP_ALUN = 8'hDD
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rf_wr_en,
  output logic                 o_rf_rd_en,
  output logic [ADDR_W-1:0]    o_rf_addr,
  output logic [WIDTH-1:0]     o_rf_wr_data,
  input  logic [WIDTH-1:0]     i_rf_rd_data,
  input  logic                 i_rf_rd_valid,
  output logic                 o_alu_en,
  output logic [FUNC_W-1:0]    o_alu_fun,
  input  logic [2*WIDTH-1:0]   i_alu_out,
  input  logic                 i_alu_valid,
  output logic                 o_clk_gate_en,
  output logic [WIDTH-1:0]     o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_ovr_err
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_ALU_A    = 4'd5,
    S_ALU_B    = 4'd6,
    S_ALU_FUN  = 4'd7,
    S_ALU_WAIT = 4'd8,
    S_TX_LO    = 4'd9,
    S_TX_HI    = 4'd10
  } state_t;

  state_t             r_state;
  logic               r_rf_wr_en;
  logic               r_rf_rd_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic               r_alu_en;
  logic [FUNC_W-1:0]  r_fun;
  logic               r_clk_gate_en;
  logic [2*WIDTH-1:0] r_result;
  logic               r_two_bytes;
  logic [WIDTH-1:0]   r_tx_data;
  logic               r_tx_valid;
  logic               r_ovr_err;

  // Frame parser, RF/ALU sequencing and transmit handshake
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_rf_wr_en    <= 1'b0;
      r_rf_rd_en    <= 1'b0;
      r_addr        <= {ADDR_W{1'b0}};
      r_wdata       <= {WIDTH{1'b0}};
      r_alu_en      <= 1'b0;
      r_fun         <= {FUNC_W{1'b0}};
      r_clk_gate_en <= 1'b0;
      r_result      <= {(2*WIDTH){1'b0}};
      r_two_bytes   <= 1'b0;
      r_tx_data     <= {WIDTH{1'b0}};
      r_tx_valid    <= 1'b0;
      r_ovr_err     <= 1'b0;
    end else begin
      r_rf_wr_en <= 1'b0;
      r_rf_rd_en <= 1'b0;
      r_alu_en   <= 1'b0;
      r_ovr_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == OP_WR) begin
              r_state <= S_WR_ADDR;
            end else if (i_rx_data == OP_RD) begin
              r_state <= S_RD_ADDR;
            end else if (i_rx_data == OP_ALU) begin
              r_state <= S_ALU_A;
            end else if (i_rx_data == OP_ALUN) begin
              r_state       <= S_ALU_FUN;
              r_clk_gate_en <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WR_ADDR: begin
          if (i_rx_valid) begin
            r_addr  <= i_rx_data[ADDR_W-1:0];
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (i_rx_valid) begin
            r_wdata    <= i_rx_data;
            r_rf_wr_en <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (i_rx_valid) begin
            r_addr     <= i_rx_data[ADDR_W-1:0];
            r_rf_rd_en <= 1'b1;
            r_state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          r_ovr_err <= i_rx_valid;
          if (i_rf_rd_valid) begin
            r_tx_data   <= i_rf_rd_data;
            r_tx_valid  <= 1'b1;
            r_two_bytes <= 1'b0;
            r_state     <= S_TX_LO;
          end
        end
        // Operands A and B land in RF locations 0 and 1 before the function byte
        S_ALU_A: begin
          if (i_rx_valid) begin
            r_addr     <= {ADDR_W{1'b0}};
            r_wdata    <= i_rx_data;
            r_rf_wr_en <= 1'b1;
            r_state    <= S_ALU_B;
          end
        end
        S_ALU_B: begin
          if (i_rx_valid) begin
            r_addr        <= ADDR_W'(1);
            r_wdata       <= i_rx_data;
            r_rf_wr_en    <= 1'b1;
            r_clk_gate_en <= 1'b1;
            r_state       <= S_ALU_FUN;
          end
        end
        S_ALU_FUN: begin
          if (i_rx_valid) begin
            r_fun    <= i_rx_data[FUNC_W-1:0];
            r_alu_en <= 1'b1;
            r_state  <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          r_ovr_err <= i_rx_valid;
          if (i_alu_valid) begin
            r_result      <= i_alu_out;
            r_clk_gate_en <= 1'b0;
            r_tx_data     <= i_alu_out[WIDTH-1:0];
            r_tx_valid    <= 1'b1;
            r_two_bytes   <= 1'b1;
            r_state       <= S_TX_LO;
          end
        end
        S_TX_LO: begin
          r_ovr_err <= i_rx_valid;
          if (i_tx_ready) begin
            if (r_two_bytes) begin
              r_tx_data <= r_result[2*WIDTH-1:WIDTH];
              r_state   <= S_TX_HI;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        S_TX_HI: begin
          r_ovr_err <= i_rx_valid;
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rf_wr_en    = r_rf_wr_en;
  assign o_rf_rd_en    = r_rf_rd_en;
  assign o_rf_addr     = r_addr;
  assign o_rf_wr_data  = r_wdata;
  assign o_alu_en      = r_alu_en;
  assign o_alu_fun     = r_fun;
  assign o_clk_gate_en = r_clk_gate_en;
  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_ovr_err     = r_ovr_err;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frame table, reset-abort sequence and random frames
// checked against a transaction-level model of the command protocol.
module tb_uart_rx_cmd_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_rf_wr_en, o_rf_rd_en;
  logic [3:0]  o_rf_addr;
  logic [7:0]  o_rf_wr_data;
  logic [7:0]  i_rf_rd_data = 8'h00;
  logic        i_rf_rd_valid = 1'b0;
  logic        o_alu_en;
  logic [3:0]  o_alu_fun;
  logic [15:0] i_alu_out = 16'h0000;
  logic        i_alu_valid = 1'b0;
  logic        o_clk_gate_en;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic        o_ovr_err;

  uart_rx_cmd_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rf_wr_en(o_rf_wr_en), .o_rf_rd_en(o_rf_rd_en), .o_rf_addr(o_rf_addr),
    .o_rf_wr_data(o_rf_wr_data), .i_rf_rd_data(i_rf_rd_data), .i_rf_rd_valid(i_rf_rd_valid),
    .o_alu_en(o_alu_en), .o_alu_fun(o_alu_fun), .i_alu_out(i_alu_out), .i_alu_valid(i_alu_valid),
    .o_clk_gate_en(o_clk_gate_en), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_ovr_err(o_ovr_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         nwr;
    logic [11:0] wr0;
    logic [11:0] wr1;
    int         nrd;
    logic [3:0] rda;
    int         nalu;
    logic [3:0] fun;
    int         ntx;
    logic [7:0] tx0;
    logic [7:0] tx1;
    int         novr;
  } exp_t;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  rd;
    logic [15:0] alu;
    int          dly;
    int          hold;
    int          extra;
    int          gap;
    exp_t        e;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [11:0] q_wr[$];
  logic [3:0]  q_rd[$];
  logic [3:0]  q_alu[$];
  logic [7:0]  q_tx[$];
  int n_ovr = 0, n_overlap = 0, n_stab = 0, n_gate = 0;
  logic pv = 1'b0, pa = 1'b0;
  logic [7:0] pd = 8'h00;
  int b_wr, b_rd, b_alu, b_tx, b_ovr;

  // Transaction monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    if (!i_rst) begin
      pv <= 1'b0;
      pa <= 1'b0;
    end else begin
      if (o_rf_wr_en) q_wr.push_back({o_rf_addr, o_rf_wr_data});
      if (o_rf_rd_en) q_rd.push_back(o_rf_addr);
      if (o_alu_en) q_alu.push_back(o_alu_fun);
      if (o_tx_valid && i_tx_ready) q_tx.push_back(o_tx_data);
      if (o_ovr_err) n_ovr <= n_ovr + 1;
      if ((32'(o_rf_wr_en) + 32'(o_rf_rd_en) + 32'(o_alu_en)) > 32'd1) n_overlap <= n_overlap + 1;
      if ((o_alu_en && !o_clk_gate_en) || (o_tx_valid && o_clk_gate_en)) n_gate <= n_gate + 1;
      if (pv && !pa && (!o_tx_valid || o_tx_data !== pd)) n_stab <= n_stab + 1;
      pv <= o_tx_valid;
      pa <= o_tx_valid && i_tx_ready;
      pd <= o_tx_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    step();
    i_rx_valid = 1'b0;
  endtask

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA: return 3;
      8'hBB: return 2;
      8'hCC: return 4;
      8'hDD: return 2;
      default: return 1;
    endcase
  endfunction

  // Protocol-level expectation: which transactions a frame must produce
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e = '{0, 12'h0, 12'h0, 0, 4'h0, 0, 4'h0, 0, 8'h0, 8'h0, 0};
    e.novr = v.extra;
    case (v.b0)
      8'hAA: begin e.nwr = 1; e.wr0 = {v.b1[3:0], v.b2}; end
      8'hBB: begin e.nrd = 1; e.rda = v.b1[3:0]; e.ntx = 1; e.tx0 = v.rd; end
      8'hCC: begin
        e.nwr = 2; e.wr0 = {4'd0, v.b1}; e.wr1 = {4'd1, v.b2};
        e.nalu = 1; e.fun = v.b3[3:0];
        e.ntx = 2; e.tx0 = v.alu[7:0]; e.tx1 = v.alu[15:8];
      end
      8'hDD: begin
        e.nalu = 1; e.fun = v.b1[3:0];
        e.ntx = 2; e.tx0 = v.alu[7:0]; e.tx1 = v.alu[15:8];
      end
      default: e.novr = 0;
    endcase
    return e;
  endfunction

  task automatic mark();
    b_wr = q_wr.size(); b_rd = q_rd.size(); b_alu = q_alu.size();
    b_tx = q_tx.size(); b_ovr = n_ovr;
  endtask

  task automatic wait_strobe(input bit alu);
    for (int i = 0; i < 20; i++) begin
      if ((!alu && o_rf_rd_en) || (alu && o_alu_en)) break;
      step();
    end
  endtask

  task automatic tx_phase(input int hold, input int ntx);
    repeat (hold) step();
    i_tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (q_tx.size() - b_tx >= ntx) break;
      step();
    end
    i_tx_ready = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int n;
    n = frame_len(v.b0);
    send_byte(v.b0);
    if (n > 1) begin repeat (v.gap) step(); send_byte(v.b1); end
    if (n > 2) begin repeat (v.gap) step(); send_byte(v.b2); end
    if (n > 3) begin repeat (v.gap) step(); send_byte(v.b3); end
    if (v.b0 == 8'hBB) begin
      wait_strobe(1'b0);
      if (v.extra != 0) send_byte(8'h5A);
      repeat (v.dly) step();
      i_rf_rd_data = v.rd; i_rf_rd_valid = 1'b1;
      step();
      i_rf_rd_valid = 1'b0;
      tx_phase(v.hold, 1);
    end else if (v.b0 == 8'hCC || v.b0 == 8'hDD) begin
      wait_strobe(1'b1);
      if (v.extra != 0) send_byte(8'h5A);
      repeat (v.dly) step();
      i_alu_out = v.alu; i_alu_valid = 1'b1;
      step();
      i_alu_valid = 1'b0;
      tx_phase(v.hold, 2);
    end
    repeat (2) step();
  endtask

  task automatic check_frame(input string tag, input exp_t e);
    chk({tag, ".nwr"}, 32'(q_wr.size() - b_wr), 32'(e.nwr));
    if (e.nwr > 0) chk({tag, ".wr0"}, 32'(q_wr[b_wr]), 32'(e.wr0));
    if (e.nwr > 1) chk({tag, ".wr1"}, 32'(q_wr[b_wr + 1]), 32'(e.wr1));
    chk({tag, ".nrd"}, 32'(q_rd.size() - b_rd), 32'(e.nrd));
    if (e.nrd > 0) chk({tag, ".rda"}, 32'(q_rd[b_rd]), 32'(e.rda));
    chk({tag, ".nalu"}, 32'(q_alu.size() - b_alu), 32'(e.nalu));
    if (e.nalu > 0) chk({tag, ".fun"}, 32'(q_alu[b_alu]), 32'(e.fun));
    chk({tag, ".ntx"}, 32'(q_tx.size() - b_tx), 32'(e.ntx));
    if (e.ntx > 0) chk({tag, ".tx0"}, 32'(q_tx[b_tx]), 32'(e.tx0));
    if (e.ntx > 1) chk({tag, ".tx1"}, 32'(q_tx[b_tx + 1]), 32'(e.tx1));
    chk({tag, ".novr"}, 32'(n_ovr - b_ovr), 32'(e.novr));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".outs"}, {22'd0, o_rf_wr_en, o_rf_rd_en, o_alu_en, o_clk_gate_en, o_tx_valid,
                         o_ovr_err, 4'd0}, 32'd0);
    chk({tag, ".addr"}, 32'(o_rf_addr), 32'd0);
    chk({tag, ".wdata"}, 32'(o_rf_wr_data), 32'd0);
    chk({tag, ".fun"}, 32'(o_alu_fun), 32'd0);
    chk({tag, ".txdata"}, 32'(o_tx_data), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    exp_t e;
    int sel;
    // b0 b1 b2 b3 rd alu dly hold extra gap {nwr wr0 wr1 nrd rda nalu fun ntx tx0 tx1 novr}
    tbl[0] = '{8'hAA, 8'h05, 8'h3C, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0,
               '{1, 12'h53C, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0}};
    tbl[1] = '{8'hBB, 8'h05, 8'h00, 8'h00, 8'h3C, 16'h0000, 3, 0, 0, 0,
               '{0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00, 0}};
    tbl[2] = '{8'hCC, 8'h12, 8'h34, 8'h01, 8'h00, 16'h0046, 2, 0, 0, 1,
               '{2, 12'h012, 12'h134, 0, 4'h0, 1, 4'h1, 2, 8'h46, 8'h00, 0}};
    tbl[3] = '{8'hDD, 8'h02, 8'h00, 8'h00, 8'h00, 16'hBEEF, 1, 10, 0, 0,
               '{0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h2, 2, 8'hEF, 8'hBE, 0}};
    tbl[4] = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0,
               '{0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0}};
    tbl[5] = '{8'hAA, 8'h01, 8'hFF, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 2,
               '{1, 12'h1FF, 12'h000, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00, 0}};
    tbl[6] = '{8'hDD, 8'h07, 8'h00, 8'h00, 8'h00, 16'h1234, 2, 1, 1, 0,
               '{0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h7, 2, 8'h34, 8'h12, 1}};
    tbl[7] = '{8'hBB, 8'h1A, 8'h00, 8'h00, 8'hA5, 16'h0000, 0, 2, 1, 0,
               '{0, 12'h000, 12'h000, 1, 4'hA, 0, 4'h0, 1, 8'hA5, 8'h00, 1}};

    repeat (3) step();
    reset_check("reset");
    i_rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      mark();
      run_frame(tbl[i]);
      check_frame($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Reset in the middle of an ALU frame must abort it cleanly
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
    step();
    chk("abort.gate_pre", 32'(o_clk_gate_en), 32'd1);
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    reset_check("abort");
    mark();
    v = '{8'hBB, 8'h00, 8'h00, 8'h00, 8'h77, 16'h0000, 1, 0, 0, 0,
          '{0, 12'h000, 12'h000, 1, 4'h0, 0, 4'h0, 1, 8'h77, 8'h00, 0}};
    run_frame(v);
    check_frame("abort.rd", v.e);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: v.b0 = 8'hAA;
        1: v.b0 = 8'hBB;
        2: v.b0 = 8'hCC;
        3: v.b0 = 8'hDD;
        default: begin
          v.b0 = 8'($urandom_range(0, 255));
          if (frame_len(v.b0) != 1) v.b0 = 8'h00;
        end
      endcase
      v.b1 = 8'($urandom); v.b2 = 8'($urandom); v.b3 = 8'($urandom);
      v.rd = 8'($urandom); v.alu = 16'($urandom);
      v.dly = $urandom_range(0, 4); v.hold = $urandom_range(0, 3);
      v.gap = $urandom_range(0, 2);
      v.extra = (sel >= 1 && sel <= 3) ? int'($urandom_range(0, 1)) : 0;
      e = model(v);
      mark();
      run_frame(v);
      check_frame($sformatf("rnd%0d", i), e);
    end

    chk("strobe_overlap", 32'(n_overlap), 32'd0);
    chk("tx_stable", 32'(n_stab), 32'd0);
    chk("clk_gate", 32'(n_gate), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
